// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory-line arbiter.
// Widths: ADDR_W line address, LINE_W line data, SEL_W byte selects (one per line byte).
// arb_req_t is the latched request that drives the pmem port for a whole transaction.
package mem_arbiter_pkg;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned SEL_W  = 16;

  typedef logic [ADDR_W-1:0] lc3b_wb_adr;
  typedef logic [LINE_W-1:0] lc3b_line;
  typedef logic [LINE_W-1:0] lc3b_c_line;
  typedef logic [15:0]       lc3b_word;
  typedef logic [SEL_W-1:0]  lc3b_mem_sel;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D
  } arb_state_t;

  typedef struct packed {
    logic        op_write;
    lc3b_wb_adr  address;
    lc3b_line    wdata;
    lc3b_mem_sel sel;
  } arb_req_t;

  // Reads always fetch the whole line; only writes honour the byte selects.
  function automatic lc3b_mem_sel sel_for_op(input logic op_write, input lc3b_mem_sel sel);
    return op_write ? sel : '1;
  endfunction

endpackage

// File: rtl/arb_req_reg.sv
// Request register for the arbiter: holds the granted request for the duration of a
// pmem transaction.
// Ports: clk, rst_n (async, active-low), load (capture next_req), next_req, req (registered).
module arb_req_reg
  import mem_arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     load,
  input  arb_req_t next_req,
  output arb_req_t req
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req <= '0;
    end else if (load) begin
      req <= next_req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one physical-memory line port between the ifetch port and the data port.
// One outstanding transaction at a time; round-robin grant on contention. The winner's
// request is latched and drives pmem_* unchanged until pmem_resp.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_read, i_address               ifetch request; i_rdata, i_resp back to ifetch
//   d_read, d_write, d_address,
//   d_wdata, d_sel                  data-port request; d_rdata, d_resp back to data port
//   pmem_read, pmem_write,
//   pmem_address, pmem_wdata,
//   pmem_sel                        registered memory-side request
//   pmem_rdata, pmem_resp           memory completion
module mem_arbiter
  import mem_arbiter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  input  logic [SEL_W-1:0]  d_sel,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  output logic [SEL_W-1:0]  pmem_sel,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  arb_state_t state;
  logic       last_grant_d;  // 1: data port won the most recent grant
  logic       i_req, d_req;
  logic       grant_i, grant_d;
  arb_req_t   next_req, req;

  always_comb begin
    i_req   = i_read;
    d_req   = d_read | d_write;
    // Under contention the port that did not win last time goes first.
    grant_i = (state == ARB_IDLE) & i_req & (~d_req | last_grant_d);
    grant_d = (state == ARB_IDLE) & d_req & (~i_req | ~last_grant_d);

    next_req = '0;
    if (grant_i) begin
      next_req.address = i_address;
      next_req.sel     = sel_for_op(1'b0, '0);
    end else begin
      // Write wins when both d_read and d_write are set.
      next_req.op_write = d_write;
      next_req.address  = d_address;
      next_req.wdata    = d_wdata;
      next_req.sel      = sel_for_op(d_write, d_sel);
    end
  end

  arb_req_reg u_req_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (grant_i | grant_d),
    .next_req (next_req),
    .req      (req)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      last_grant_d <= 1'b1;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
    end else begin
      unique case (state)
        ARB_IDLE: begin
          if (grant_i) begin
            state        <= ARB_SERVE_I;
            last_grant_d <= 1'b0;
            pmem_read    <= 1'b1;
            pmem_write   <= 1'b0;
          end else if (grant_d) begin
            state        <= ARB_SERVE_D;
            last_grant_d <= 1'b1;
            pmem_read    <= ~d_write;
            pmem_write   <= d_write;
          end
        end
        ARB_SERVE_I, ARB_SERVE_D: begin
          if (pmem_resp) begin
            state      <= ARB_IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= ARB_IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

  assign pmem_address = req.address;
  assign pmem_wdata   = req.wdata;
  assign pmem_sel     = req.sel;

  assign i_resp  = pmem_resp & (state == ARB_SERVE_I);
  assign d_resp  = pmem_resp & (state == ARB_SERVE_D);
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              i_read = 1'b0;
  logic [ADDR_W-1:0] i_address = '0;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic              d_read = 1'b0;
  logic              d_write = 1'b0;
  logic [ADDR_W-1:0] d_address = '0;
  logic [LINE_W-1:0] d_wdata = '0;
  logic [SEL_W-1:0]  d_sel = '0;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [SEL_W-1:0]  pmem_sel;
  logic [LINE_W-1:0] pmem_rdata = '0;
  logic              pmem_resp = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: which port owns the memory and what request it made.
  bit                m_busy;
  bit                m_own_d;
  bit                m_last_d;
  bit                m_write;
  logic [ADDR_W-1:0] m_addr;
  logic [LINE_W-1:0] m_wdata;
  logic [SEL_W-1:0]  m_sel;

  mem_arbiter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_read       (i_read),
    .i_address    (i_address),
    .i_rdata      (i_rdata),
    .i_resp       (i_resp),
    .d_read       (d_read),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_wdata      (d_wdata),
    .d_sel        (d_sel),
    .d_rdata      (d_rdata),
    .d_resp       (d_resp),
    .pmem_read    (pmem_read),
    .pmem_write   (pmem_write),
    .pmem_address (pmem_address),
    .pmem_wdata   (pmem_wdata),
    .pmem_sel     (pmem_sel),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy   = 0;
    m_own_d  = 0;
    m_last_d = 1;
    m_write  = 0;
    m_addr   = '0;
    m_wdata  = '0;
    m_sel    = '0;
  endtask

  // Arbitration rules applied at a rising edge to the inputs present before it.
  task automatic model_edge();
    bit ir;
    bit dr;
    bit pick_d;
    ir = i_read;
    dr = d_read | d_write;
    if (!m_busy) begin
      if (ir || dr) begin
        pick_d   = (ir && dr) ? !m_last_d : dr;
        m_busy   = 1;
        m_own_d  = pick_d;
        m_last_d = pick_d;
        if (pick_d) begin
          m_write = d_write;
          m_addr  = d_address;
          m_wdata = d_wdata;
          m_sel   = d_write ? d_sel : '1;
        end else begin
          m_write = 0;
          m_addr  = i_address;
          m_sel   = '1;
        end
      end
    end else if (pmem_resp) begin
      m_busy = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    i_read    = 0;
    d_read    = 0;
    d_write   = 0;
    pmem_resp = 0;
    rst_n     = 0;
    #2;
    rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      n_err++; $display("FAIL reset_strobes: got r=%b w=%b want 0 0", pmem_read, pmem_write);
    end
    n_vec++; if (pmem_address !== '0 || pmem_sel !== '0 || pmem_wdata !== '0) begin
      n_err++; $display("FAIL reset_regs: got a=%h s=%h w=%h want 0", pmem_address, pmem_sel,
                        pmem_wdata);
    end
    n_vec++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      n_err++; $display("FAIL reset_resp: got i=%b d=%b want 0 0", i_resp, d_resp);
    end
    rst_n = 1;
  endtask

  task automatic test_single_ifetch();
    logic [LINE_W-1:0] rd;
    rd        = {16{8'hA5}};
    i_read    = 1;
    i_address = 12'h012;
    step();
    for (int c = 0; c < 3; c++) begin
      n_vec++; if (pmem_read !== 1'b1 || pmem_write !== 1'b0 || pmem_address !== 12'h012) begin
        n_err++; $display("FAIL ifetch_hold c%0d: got r=%b w=%b a=%h want 1 0 012", c, pmem_read,
                          pmem_write, pmem_address);
      end
      n_vec++; if (pmem_sel !== 16'hFFFF) begin
        n_err++; $display("FAIL ifetch_sel: got %h want ffff", pmem_sel);
      end
      if (c < 2) step();
    end
    pmem_resp  = 1;
    pmem_rdata = rd;
    #1;
    n_vec++; if (i_resp !== 1'b1 || d_resp !== 1'b0 || i_rdata !== rd) begin
      n_err++; $display("FAIL ifetch_resp: got i=%b d=%b data=%h want 1 0 %h", i_resp, d_resp,
                        i_rdata, rd);
    end
    i_read = 0;
    step();
    pmem_resp = 0;
    #1;
    n_vec++; if (pmem_read !== 1'b0 || i_resp !== 1'b0) begin
      n_err++; $display("FAIL ifetch_done: got r=%b resp=%b want 0 0", pmem_read, i_resp);
    end
  endtask

  task automatic test_alternation();
    bit                exp_d;
    logic [LINE_W-1:0] rd;
    do_reset();
    i_read    = 1;
    i_address = 12'h012;
    d_read    = 1;
    d_address = 12'h400;
    for (int t = 0; t < 4; t++) begin
      exp_d = (t % 2) == 1;  // I first after reset, then alternate
      step();
      n_vec++; if (pmem_address !== (exp_d ? 12'h400 : 12'h012) || pmem_read !== 1'b1) begin
        n_err++; $display("FAIL alt_grant t%0d: got a=%h r=%b want %s", t, pmem_address,
                          pmem_read, exp_d ? "400 1" : "012 1");
      end
      step();
      rd         = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata = rd;
      pmem_resp  = 1;
      #1;
      n_vec++; if (i_resp !== !exp_d || d_resp !== exp_d) begin
        n_err++; $display("FAIL alt_resp t%0d: got i=%b d=%b want i=%b d=%b", t, i_resp, d_resp,
                          !exp_d, exp_d);
      end
      n_vec++; if ((exp_d ? d_rdata : i_rdata) !== rd) begin
        n_err++; $display("FAIL alt_rdata t%0d: got %h want %h", t,
                          exp_d ? d_rdata : i_rdata, rd);
      end
      step();
      pmem_resp = 0;
    end
    i_read = 0;
    d_read = 0;
  endtask

  task automatic test_write();
    logic [LINE_W-1:0] wd;
    wd        = {8{16'hDEAD}};
    do_reset();
    d_write   = 1;
    d_address = 12'h3FF;
    d_wdata   = wd;
    d_sel     = 16'h0003;
    step();
    d_wdata = '0;
    d_sel   = '1;
    for (int c = 0; c < 3; c++) begin
      n_vec++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin
        n_err++; $display("FAIL write_strobe c%0d: got w=%b r=%b want 1 0", c, pmem_write,
                          pmem_read);
      end
      n_vec++; if (pmem_sel !== 16'h0003 || pmem_wdata !== wd || pmem_address !== 12'h3FF) begin
        n_err++; $display("FAIL write_data c%0d: got s=%h a=%h w=%h want 0003 3ff %h", c, pmem_sel,
                          pmem_address, pmem_wdata, wd);
      end
      step();
    end
    d_write   = 0;
    pmem_resp = 1;
    #1;
    n_vec++; if (d_resp !== 1'b1 || i_resp !== 1'b0) begin
      n_err++; $display("FAIL write_resp: got d=%b i=%b want 1 0", d_resp, i_resp);
    end
    step();
    pmem_resp = 0;
    n_vec++; if (pmem_write !== 1'b0) begin
      n_err++; $display("FAIL write_clear: got %b want 0", pmem_write);
    end
  endtask

  task automatic test_addr_change();
    do_reset();
    d_read    = 1;
    d_address = 12'h2A0;
    step();
    d_address = 12'h111;
    for (int c = 0; c < 3; c++) begin
      step();
      n_vec++; if (pmem_address !== 12'h2A0 || pmem_read !== 1'b1) begin
        n_err++; $display("FAIL addr_hold c%0d: got a=%h r=%b want 2a0 1", c, pmem_address,
                          pmem_read);
      end
    end
    d_read    = 0;
    pmem_resp = 1;
    #1;
    n_vec++; if (d_resp !== 1'b1) begin
      n_err++; $display("FAIL addr_resp: got %b want 1", d_resp);
    end
    step();
    pmem_resp = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_read    = 1;
    i_address = 12'h055;
    step();
    n_vec++; if (pmem_read !== 1'b1) begin
      n_err++; $display("FAIL rstmid_pre: got %b want 1", pmem_read);
    end
    #2;
    rst_n = 0;
    #1;
    model_reset();
    n_vec++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0 || pmem_address !== '0 ||
                 pmem_sel !== '0) begin
      n_err++; $display("FAIL rstmid_clear: got r=%b w=%b a=%h s=%h want all 0", pmem_read,
                        pmem_write, pmem_address, pmem_sel);
    end
    i_read = 0;
    rst_n  = 1;
    #1;
    pmem_resp = 1;
    #1;
    n_vec++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      n_err++; $display("FAIL rstmid_resp: got i=%b d=%b want 0 0", i_resp, d_resp);
    end
    step();
    pmem_resp = 0;
    n_vec++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin
      n_err++; $display("FAIL rstmid_idle: got r=%b w=%b want 0 0", pmem_read, pmem_write);
    end
  endtask

  task automatic test_rw_both();
    do_reset();
    d_read    = 1;
    d_write   = 1;
    d_address = 12'h0C3;
    d_sel     = 16'h00F0;
    step();
    n_vec++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0 || pmem_sel !== 16'h00F0) begin
      n_err++; $display("FAIL rw_both: got w=%b r=%b s=%h want 1 0 00f0", pmem_write, pmem_read,
                        pmem_sel);
    end
    d_read    = 0;
    d_write   = 0;
    pmem_resp = 1;
    step();
    // Stray completion while idle must not produce a response or a grant.
    #1;
    n_vec++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin
      n_err++; $display("FAIL idle_resp: got i=%b d=%b want 0 0", i_resp, d_resp);
    end
    step();
    pmem_resp = 0;
    n_vec++; if (pmem_write !== 1'b0 || pmem_read !== 1'b0) begin
      n_err++; $display("FAIL idle_state: got w=%b r=%b want 0 0", pmem_write, pmem_read);
    end
  endtask

  task automatic test_random();
    bit exp_i;
    bit exp_d;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      i_read     = ($urandom % 3) != 0;
      d_read     = ($urandom % 2) != 0;
      d_write    = ($urandom % 3) == 0;
      i_address  = ADDR_W'($urandom);
      d_address  = ADDR_W'($urandom);
      d_wdata    = {$urandom, $urandom, $urandom, $urandom};
      d_sel      = SEL_W'($urandom);
      pmem_rdata = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp  = m_busy ? (($urandom % 3) == 0) : (($urandom % 6) == 0);
      #1;
      exp_i = m_busy && !m_own_d && pmem_resp;
      exp_d = m_busy && m_own_d && pmem_resp;
      n_vec++; if (i_resp !== exp_i || d_resp !== exp_d) begin
        n_err++; $display("FAIL rnd_resp c%0d: got i=%b d=%b want i=%b d=%b", c, i_resp, d_resp,
                          exp_i, exp_d);
      end
      if (exp_i || exp_d) begin
        n_vec++; if ((exp_d ? d_rdata : i_rdata) !== pmem_rdata) begin
          n_err++; $display("FAIL rnd_rdata c%0d: got %h want %h", c,
                            exp_d ? d_rdata : i_rdata, pmem_rdata);
        end
      end
      step();
      n_vec++; if (pmem_read !== (m_busy && !m_write) || pmem_write !== (m_busy && m_write)) begin
        n_err++; $display("FAIL rnd_strobe c%0d: got r=%b w=%b want r=%b w=%b", c, pmem_read,
                          pmem_write, m_busy && !m_write, m_busy && m_write);
      end
      n_vec++; if (pmem_address !== m_addr || pmem_sel !== m_sel) begin
        n_err++; $display("FAIL rnd_req c%0d: got a=%h s=%h want a=%h s=%h", c, pmem_address,
                          pmem_sel, m_addr, m_sel);
      end
      if (m_write) begin
        n_vec++; if (pmem_wdata !== m_wdata) begin
          n_err++; $display("FAIL rnd_wdata c%0d: got %h want %h", c, pmem_wdata, m_wdata);
        end
      end
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_ifetch();
    test_alternation();
    test_write();
    test_addr_change();
    test_reset_mid();
    test_rw_both();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
